// File: rtl/dct_trace_arbiter_if.sv
// Handshake bundle for the two DCT trace sources and the trace RAM write port.
interface dct_trace_arbiter_if #(
  parameter int ADDR_W = 7
);
  logic              src0_valid;
  logic [29:0]       src0_buffer;
  logic [3:0]        src0_count;
  logic              src0_ready;
  logic              src1_valid;
  logic [29:0]       src1_buffer;
  logic [3:0]        src1_count;
  logic              src1_ready;
  logic              tw_wr;
  logic [ADDR_W-1:0] tw_addr;
  logic [34:0]       tw_data;

  modport master (
    output src0_valid, src0_buffer, src0_count,
    output src1_valid, src1_buffer, src1_count,
    input  src0_ready, src1_ready,
    input  tw_wr, tw_addr, tw_data
  );

  modport slave (
    input  src0_valid, src0_buffer, src0_count,
    input  src1_valid, src1_buffer, src1_count,
    output src0_ready, src1_ready,
    output tw_wr, tw_addr, tw_data
  );
endinterface

// File: rtl/dct_trace_arbiter.sv
// Round-robin arbiter sharing the DCT trace sink between two packers; writes
// accepted words to a circular trace RAM and runs the capture stop sequence.
module dct_trace_arbiter #(
  parameter int ADDR_W      = 7,
  parameter int DRAIN_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic               test_ending_i,
  dct_trace_arbiter_if.slave bus,
  output logic               test_has_ended_o,
  output logic               wrapped_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ENDED = 2'd3
  } state_e;

  localparam logic [7:0]        DRAIN_LAST = 8'(DRAIN_LIMIT - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1'b1);

  state_e            state_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [7:0]        drain_cnt_q;
  logic              tw_wr_q;
  logic [ADDR_W-1:0] tw_addr_q;
  logic [34:0]       tw_data_q;
  logic              wrapped_q;
  logic              ended_q;

  logic active_d;
  logic grant0_d;
  logic grant1_d;
  logic accept_d;

  // Arbitration: a lone valid wins; on a tie the source not granted last time wins.
  always_comb begin
    active_d = (state_q == RUN) || (state_q == DRAIN);
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (active_d) begin
      grant0_d = bus.src0_valid && (!bus.src1_valid || last_grant_q);
      grant1_d = bus.src1_valid && (!bus.src0_valid || !last_grant_q);
    end else begin
      grant0_d = 1'b0;
      grant1_d = 1'b0;
    end
    accept_d = grant0_d || grant1_d;
  end

  // Control FSM, write pipeline and sticky status, all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ptr_q        <= '0;
      drain_cnt_q  <= 8'd0;
      tw_wr_q      <= 1'b0;
      tw_addr_q    <= '0;
      tw_data_q    <= 35'd0;
      wrapped_q    <= 1'b0;
      ended_q      <= 1'b0;
    end else begin
      tw_wr_q <= accept_d;
      if (accept_d) begin
        tw_addr_q    <= ptr_q;
        tw_data_q    <= grant1_d ? {1'b1, bus.src1_count, bus.src1_buffer}
                                 : {1'b0, bus.src0_count, bus.src0_buffer};
        ptr_q        <= ptr_q + PTR_ONE;
        last_grant_q <= grant1_d;
      end
      // Wrap becomes visible only once the last-address write has been issued.
      if (tw_wr_q && (&tw_addr_q)) begin
        wrapped_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (test_ending_i || !enable_i) begin
            state_q     <= DRAIN;
            drain_cnt_q <= 8'd0;
          end
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 8'd1;
          if ((!bus.src0_valid && !bus.src1_valid) || (drain_cnt_q == DRAIN_LAST)) begin
            state_q <= ENDED;
            ended_q <= 1'b1;
          end
        end
        ENDED: begin
          if (!enable_i) begin
            state_q <= IDLE;
            ended_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ended_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.src0_ready   = grant0_d;
  assign bus.src1_ready   = grant1_d;
  assign bus.tw_wr        = tw_wr_q;
  assign bus.tw_addr      = tw_addr_q;
  assign bus.tw_data      = tw_data_q;
  assign test_has_ended_o = ended_q;
  assign wrapped_o        = wrapped_q;
  assign state_o          = state_q;

endmodule
